// File: rtl/apb_ctrl_pkg.sv
// Shared types for the APB master/arbiter slice: controller states,
// default bus widths and the response record returned to requesters.
package apb_ctrl_pkg;

  localparam int unsigned APB_ADDR_W = 32;
  localparam int unsigned APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_state_e;

  typedef struct packed {
    logic [APB_DATA_W-1:0] rdata;
    logic                  err;
  } apb_rsp_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first asserted request
// after last_grant, wrapping modulo N. Returns one-hot and encoded grant.
module rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last_grant) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin arbitration between command
// sources, SETUP/ACCESS sequencing, wait states, slave error and timeout.
module apb_master_arb
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  input  logic [DATA_W-1:0]         prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  apb_state_e         state, state_d;
  logic [IDX_W-1:0]   last_grant, cur_g, gidx;
  logic [NUM_REQ-1:0] gnt;
  logic               gany;
  logic [CNT_W-1:0]   wcnt;
  logic               tout;

  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req        (req_valid),
    .last_grant (last_grant),
    .gnt        (gnt),
    .idx        (gidx),
    .any        (gany)
  );

  // pready on the final allowed cycle wins over the timeout
  assign tout = (TIMEOUT != 0) && (state == ACCESS) && !pready &&
                (wcnt == CNT_W'(TIMEOUT));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (gany) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (pready || tout) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur_g      <= '0;
      wcnt       <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      psel       <= 1'b0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
    end else begin
      state     <= state_d;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      psel      <= (state_d == SETUP) || (state_d == ACCESS);
      penable   <= (state_d == ACCESS);
      case (state)
        IDLE: begin
          if (gany) begin
            req_ready <= gnt;
            cur_g     <= gidx;
            pwrite    <= req_write[gidx];
            paddr     <= req_addr[32'(gidx) * ADDR_W +: ADDR_W];
            pwdata    <= req_wdata[32'(gidx) * DATA_W +: DATA_W];
          end
        end
        SETUP: wcnt <= CNT_W'(1);
        ACCESS: begin
          if (pready) begin
            rsp_valid <= NUM_REQ'(1) << cur_g;
            rsp_rdata <= pwrite ? '0 : prdata;
            rsp_err   <= pslverr;
          end else if (tout) begin
            rsp_valid <= NUM_REQ'(1) << cur_g;
            rsp_err   <= 1'b1;
          end else begin
            wcnt <= wcnt + CNT_W'(1);
          end
        end
        RESP: last_grant <= cur_g;
        default: ;
      endcase
    end
  end

endmodule
